// File: rtl/puf_enroll_path_pkg.sv
// Shared constants, FSM encoding and bit-serial step functions for the PUF enrollment path.
package puf_enroll_path_pkg;

  localparam int DATA_W = 256;
  localparam int BLK_W  = 32;
  localparam int NBLK   = 8;
  localparam int PAR_W  = 12;
  localparam int HLP_W  = NBLK * PAR_W;

  localparam logic [PAR_W-1:0] POLY      = 12'h80F;
  // Taps at lfsr[7], lfsr[5], lfsr[4], lfsr[3]
  localparam logic [7:0]       LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] lfsr);
    return {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  endfunction

  function automatic logic [PAR_W-1:0] rem_next(input logic [PAR_W-1:0] rem, input logic s);
    logic fb;
    fb = s ^ rem[PAR_W-1];
    return {rem[PAR_W-2:0], 1'b0} ^ (fb ? POLY : {PAR_W{1'b0}});
  endfunction

endpackage

// File: rtl/puf_bch_par_ser.sv
// Serial cyclic-code remainder engine; one bit per enabled clock, clear has priority.
module puf_bch_par_ser
  import puf_enroll_path_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [PAR_W-1:0] rem_out
);

  // Remainder register update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_out <= {PAR_W{1'b0}};
    end else if (clr) begin
      rem_out <= {PAR_W{1'b0}};
    end else if (en) begin
      rem_out <= rem_next(rem_out, bit_in);
    end else begin
      rem_out <= rem_out;
    end
  end

endmodule

// File: rtl/puf_enroll_path.sv
// PUF enrollment datapath: LFSR-scrambles a 256-bit response bit-serially and
// produces 8 x 12-bit cyclic-code helper words over the scrambled stream.
module puf_enroll_path
  import puf_enroll_path_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        seed,
  input  logic [0:DATA_W-1] data_in,
  output logic              busy,
  output logic              done,
  output logic [0:DATA_W-1] scr_out,
  output logic [0:HLP_W-1]  helper
);

  state_t            state_r;
  logic [7:0]        cnt_r;
  logic [7:0]        lfsr_r;
  logic [0:DATA_W-1] data_r;

  logic              scr_bit_s;
  logic              blk_end_s;
  logic              rem_clr_s;
  logic              rem_en_s;
  logic [PAR_W-1:0]  rem_s;
  logic [PAR_W-1:0]  rem_nxt_s;
  logic [2:0]        blk_idx_s;

  // Per-bit scramble and remainder control for the current shift cycle
  always_comb begin
    scr_bit_s = data_r[0] ^ lfsr_r[7];
    blk_end_s = (cnt_r[4:0] == 5'd31);
    blk_idx_s = cnt_r[7:5];
    rem_nxt_s = rem_next(rem_s, scr_bit_s);
    rem_en_s  = 1'b0;
    rem_clr_s = 1'b0;
    if (state_r == ST_LOAD) begin
      rem_clr_s = 1'b1;
    end else if (state_r == ST_SHIFT) begin
      rem_en_s  = 1'b1;
      rem_clr_s = blk_end_s;
    end else begin
      rem_clr_s = 1'b0;
    end
  end

  puf_bch_par_ser u_par (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rem_clr_s),
    .en      (rem_en_s),
    .bit_in  (scr_bit_s),
    .rem_out (rem_s)
  );

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      lfsr_r  <= 8'd0;
      data_r  <= {DATA_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      scr_out <= {DATA_W{1'b0}};
      helper  <= {HLP_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= ST_LOAD;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          data_r  <= data_in;
          lfsr_r  <= seed;
          cnt_r   <= 8'd0;
          scr_out <= {DATA_W{1'b0}};
          helper  <= {HLP_W{1'b0}};
          state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          scr_out[cnt_r] <= scr_bit_s;
          data_r         <= {data_r[1:DATA_W-1], 1'b0};
          lfsr_r         <= lfsr_next(lfsr_r);
          cnt_r          <= cnt_r + 8'd1;
          // Remainder MSB lands at the lowest index of the block's helper slot
          if (blk_end_s) begin
            helper[int'(blk_idx_s)*PAR_W +: PAR_W] <= rem_nxt_s;
          end else begin
            helper <= helper;
          end
          if (cnt_r == 8'd255) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_enroll_path.sv
// Scoreboard bench for puf_enroll_path: stimulus pushes model results, a monitor checks on done.
module tb_puf_enroll_path;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    seed = 8'd0;
  logic [0:255]  data_in = '0;
  logic          busy;
  logic          done;
  logic [0:255]  scr_out;
  logic [0:95]   helper;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = 0;

  typedef struct {
    logic [0:255] scr;
    logic [0:95]  hlp;
    int           start_c;
    bit           gap;
  } exp_t;
  exp_t exp_q[$];

  puf_enroll_path dut (
    .clk     (clk),
    .reset_n (rst_n),
    .start   (start),
    .seed    (seed),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .scr_out (scr_out),
    .helper  (helper)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference: scramble with LFSR keystream, 12-bit remainder per 32-bit block
  task automatic model(input logic [0:255] d, input logic [7:0] sd,
                       output logic [0:255] scr, output logic [0:95] hlp);
    logic [7:0]  l;
    logic [11:0] r;
    logic        s;
    logic        fb;
    l = sd; r = 12'h000; scr = '0; hlp = '0;
    for (int i = 0; i < 256; i++) begin
      s  = d[i] ^ l[7];
      l  = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      scr[i] = s;
      fb = s ^ r[11];
      r  = {r[10:0], 1'b0} ^ (fb ? 12'h80F : 12'h000);
      if (i % 32 == 31) begin
        hlp[12*(i/32) +: 12] = r;
        r = 12'h000;
      end
    end
  endtask

  task automatic push(input logic [0:255] d, input logic [7:0] sd, input int sc, input bit gap);
    exp_t e;
    model(d, sd, e.scr, e.hlp);
    e.start_c = sc;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int n);
    int base;
    base = done_cnt;
    for (int i = 0; i < 300 * n && done_cnt < base + n; i++) @(negedge clk);
    if (done_cnt < base + n) begin
      tests++; fails++;
      $display("FAIL done_timeout: got %0d pulses expected %0d", done_cnt - base, n);
    end
  endtask

  task automatic run(input logic [0:255] d, input logic [7:0] sd);
    @(negedge clk);
    data_in = d; seed = sd; start = 1'b1;
    @(posedge clk); #1;
    push(d, sd, cyc, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1);
  endtask

  function automatic logic [0:255] rand_data();
    logic [0:255] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
    return d;
  endfunction

  // Monitor: compare each done pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("scr_out", scr_out, e.scr);
        check("helper", helper, e.hlp);
        check("busy_at_done", busy, 0);
        if (e.gap) check("done_gap", cyc - last_done, 259);
        else       check("latency", cyc - e.start_c, 257);
      end
      last_done = cyc;
    end
  end

  initial begin
    logic [0:255] d;
    logic [0:255] d2;
    logic [0:7]   head;
    logic [7:0]   sd;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_scr", scr_out, 0);
    check("rst_helper", helper, 0);
    rst_n = 1'b1;

    // Prior run so outputs hold nonzero data, then abort a run at cnt=100
    run(rand_data(), 8'hA5);
    @(negedge clk);
    data_in = rand_data(); seed = 8'h3C; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (101) @(posedge clk);
    #2;
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_scr", scr_out, 0);
    check("abort_helper", helper, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(rand_data(), 8'h5A);

    // All-zero input and seed
    run('0, 8'h00);
    check("zero_scr", scr_out, 0);
    check("zero_helper", helper, 0);

    // Single bit at the end of block 0, then one before it
    d = '0; d[31] = 1'b1;
    run(d, 8'h00);
    check("bit31_helper", helper, {12'h80F, 84'd0});
    check("bit31_scr", scr_out, d);
    d = '0; d[30] = 1'b1;
    run(d, 8'h00);
    check("bit30_helper", helper, {12'h811, 84'd0});
    check("bit30_scr", scr_out, d);

    // Keystream only: first set bit at position 7
    run('0, 8'h01);
    head = scr_out[0:7];
    check("seed01_head", head, 8'h01);

    // Start re-pulses and input changes during a run are ignored
    d = rand_data(); sd = 8'hC3;
    @(negedge clk);
    data_in = d; seed = sd; start = 1'b1;
    @(posedge clk); #1;
    push(d, sd, cyc, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; data_in = rand_data(); seed = ~sd;
    @(negedge clk);
    start = 1'b0;
    repeat (194) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1);
    repeat (3) @(negedge clk);
    check("repulse_idle", busy, 0);

    // Start held high: back-to-back runs on identical inputs
    d2 = rand_data();
    @(negedge clk);
    data_in = d2; seed = 8'h77; start = 1'b1;
    @(posedge clk); #1;
    push(d2, 8'h77, cyc, 1'b0);
    push(d2, 8'h77, 0, 1'b1);
    wait_done(2);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("held_stop", busy, 0);

    for (int n = 0; n < 16; n++) run(rand_data(), 8'($urandom_range(0, 255)));

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
